// File: rtl/store_merge_mem.sv
// MEM-stage store unit: narrows a register value into a byte/halfword/word lane
// of word-addressed synchronous RAM via read-modify-write, reporting done/misalign.
module store_merge_mem #(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | RAM read of target word (sb/sh only)
    // WRITE | mem_we high, merged or full word written
    // DONE  | one-cycle done pulse, misalign valid
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [1:0] OP_SW = 2'b00;
    localparam logic [1:0] OP_SH = 2'b01;
    localparam logic [1:0] OP_SB = 2'b10;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          op_q;
    logic [MEM_AW+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                mis_q;
    logic                req_mis;
    logic                accept;
    logic [31:0]         merged;
    logic                unused_addr_hi;

    // Upper address bits are dropped on purpose: addresses wrap modulo RAM size.
    assign unused_addr_hi = ^addr[31:MEM_AW+2];

    assign accept = (state == IDLE) && start;

    always_comb begin
        req_mis = 1'b0;
        case (op)
            OP_SW:   req_mis = (addr[1:0] != 2'b00);
            OP_SH:   req_mis = addr[0];
            OP_SB:   req_mis = 1'b0;
            default: req_mis = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q    <= op;
                addr_q  <= addr[MEM_AW+1:0];
                wdata_q <= wdata;
                mis_q   <= req_mis;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (req_mis)         state_nxt = DONE;
                    else if (op == OP_SW) state_nxt = WRITE;
                    else                 state_nxt = READ;
                end
            end
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        case (op_q)
            OP_SW: merged = wdata_q;
            OP_SH: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            OP_SB:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            default: merged = mem_rdata;
        endcase
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign misalign  = (state == DONE) && mis_q;
    assign mem_we    = (state == WRITE);
    assign mem_addr  = addr_q[MEM_AW+1:2];
    assign mem_wdata = (state == WRITE) ? merged : 32'h0;

endmodule

// File: doc/store_merge_mem.md
Name: store_merge_MEM

Overview:
- MEM-stage store unit for the multi-cycle CPU; the write-side counterpart of ID-stage immediate/load extension.
- Loads widen narrow fields to 32 bits; this block narrows a 32-bit register value into a byte or halfword lane of a memory word.
- Performs read-modify-write on word-addressed synchronous data RAM for sb/sh, and a direct write for sw.
- Reports completion and misalignment to the control FSM.

Parameters:
- MEM_AW, 10, word-address width of data RAM (RAM depth 2^MEM_AW words).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  store request; sampled only in IDLE.
- op  input  2  store type: 00 sw, 01 sh, 10 sb, 11 reserved.
- addr  input  32  byte address from ALU.
- wdata  input  32  register rt value to store.
- busy  output  1  high from the cycle after start acceptance until DONE exits.
- done  output  1  one-cycle completion pulse.
- misalign  output  1  valid with done; 1 = request rejected, no memory write.
- mem_addr  output  MEM_AW  RAM word address.
- mem_we  output  1  RAM write enable.
- mem_wdata  output  32  RAM write data.
- mem_rdata  input  32  RAM read data; valid one cycle after mem_addr is presented (synchronous read).

Behaviour:
- Reset (async, immediate) values: state IDLE, busy 0, done 0, misalign 0, mem_we 0, mem_addr 0, mem_wdata 0. Latched request registers cleared.
- Latching: in IDLE with start=1, latch op, addr, wdata on the clock edge. Inputs are ignored afterwards until return to IDLE.
- start while busy is ignored, not queued.
- Misalignment check at acceptance:
  - sw with addr[1:0]≠0.
  - sh with addr[0]=1.
  - op=11.
  - Misaligned requests go IDLE→DONE with misalign=1. mem_we stays 0 throughout.
- mem_addr = latched addr[MEM_AW+1:2]. Upper address bits are ignored, so addresses wrap modulo RAM size.
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE: start & misaligned → DONE. start & sw → WRITE. start & (sh|sb) → READ.
  - READ: mem_addr driven, mem_we=0; always → WRITE.
  - WRITE: mem_we=1 for exactly this cycle; → DONE.
  - DONE: done=1 for one cycle, misalign per request; → IDLE. busy=1 in READ/WRITE/DONE.
- Write data formation in WRITE (little-endian; byte k = bits [8k+7:8k]):
  - sw: mem_wdata = wdata.
  - sb: mem_wdata = mem_rdata with byte lane addr[1:0] replaced by wdata[7:0]; other three bytes unchanged.
  - sh: mem_wdata = mem_rdata with halfword lane addr[1] replaced by wdata[15:0]; other half unchanged.
- Latency from accepting edge to done high:
  - sw: 2 cycles.
  - sb/sh: 3 cycles.
  - misaligned: 1 cycle.
- Back-to-back: a new start is accepted in the IDLE cycle following DONE, so throughput is one store per 3 (sw) or 4 (sb/sh) cycles.
- Reset mid-operation: FSM returns to IDLE asynchronously and mem_we drops immediately. A store in READ leaves RAM untouched. No done pulse is produced for the aborted request.
- mem_addr holds its last value in IDLE/DONE. mem_wdata is don't-care while mem_we=0 but must be deterministic (registered or held).

Test Plan:
- sw addr=0x0000_0010, wdata=0xDEADBEEF → WRITE one cycle later with mem_addr=4, mem_we=1, mem_wdata=0xDEADBEEF; done next cycle, misalign=0.
- RAM[4]=0x11223344; sb addr=0x12, wdata=0xFFFFFFAA → READ then WRITE mem_wdata=0x11AA3344; done 3 cycles after start, misalign=0.
- RAM[4]=0x11223344; sh addr=0x12, wdata=0x0000BEEF → mem_wdata=0xBEEF3344. Repeat with addr=0x10 → 0x1122BEEF.
- sh addr=0x13, and sw addr=0x12, and op=11 → done with misalign=1 one cycle after start; mem_we never asserted; RAM unchanged.
- start held high continuously during an sb → second request accepted only in the IDLE cycle after done. Inputs changed mid-operation do not affect the first write.
- Assert reset during READ of an sb → busy, done, mem_we read 0 immediately; RAM unchanged. After release, a fresh sw completes normally.
